rect_fill_engine: RTL
=====================

# rect_fill_engine

Parametrised rectangle rasteriser for the VGA-adapter path: captures an origin, runtime width/height and colour on a one-cycle `start`, then emits one pixel write per clock in column-major order. It succeeds the fixed-size brick rectangle drawer and adds:
- runtime dimensions
- a per-job colour
- a busy/done handshake
- zero-size handling
- an optional outline-only mode

Brick, paddle and ball drawers sit upstream of it; the VGA adapter's `plot`/`x`/`y`/`colour` inputs sit downstream.

## Interface
- `COORD_W`, 10, width of origin and pixel coordinates
- `DIM_W`, 6, width of rectangle width/height inputs (max 2^DIM_W−1 pixels per side)
- `COLOR_W`, 3, colour width
- `clk`  in  1  system clock, rising edge
- `resetn`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle job request; sampled only in IDLE
- `x_in`, `y_in`  in  COORD_W each  top-left origin
- `w_in`, `h_in`  in  DIM_W each  rectangle width and height in pixels
- `color_in`  in  COLOR_W  fill colour
- `outline_in`  in  1  outline-only request (present only with RECT_OUTLINE_EN)
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle after `done`
- `done`  out  1  one-cycle completion pulse
- `writeEn`  out  1  pixel write strobe
- `x_out`, `y_out`  out  COORD_W each  pixel coordinate, valid when `writeEn`=1
- `color_out`  out  COLOR_W  captured colour, held for the whole job

## Operation
- States: IDLE, DRAW, DONE.
- IDLE:
  - On `start`=1, register `x_in`, `y_in`, `w_in`, `h_in`, `color_in` (and `outline_in`) and clear `qx`=`qy`=0.
  - If `w_in`=0 or `h_in`=0, go to DONE with no writes; otherwise go to DRAW.
- DRAW:
  - Each cycle: `x_out`=x0+`qx`, `y_out`=y0+`qy`, `writeEn`=1.
  - Inner loop runs `qy` 0..h−1. At `qy`=h−1, `qy`←0 and `qx`←`qx`+1.
  - When `qx`=w−1 and `qy`=h−1, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in DRAW and DONE.
- `start` while `busy` is ignored; there is no queueing.
- Coordinate sums are COORD_W-bit and wrap modulo 2^COORD_W. No clipping is performed.
- Counters `qx`/`qy` are DIM_W bits and never exceed dim−1.
- Outputs are driven from registers and counters; there is no combinational path from `start` to `writeEn`.
- `color_out` holds the last captured colour, including in IDLE.
- Reset (asynchronous, any state):
  - State→IDLE.
  - `busy`, `done`, `writeEn` → 0.
  - `x_out`, `y_out`, `color_out` → 0.
  - A job in flight is abandoned with no `done`.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..w·h: one write per cycle.
  - First write at cycle 1: (x0, y0).
  - Second write: (x0, y0+1).
  - Last write at cycle w·h: (x0+w−1, y0+h−1).
- Cycle w·h+1: `done`=1, `writeEn`=0.
- Cycle w·h+2: IDLE; a new `start` is accepted at this cycle or later.
- Zero-size job: `done` at cycle 1 and no writes.
- `start` asserted in the same cycle as `done` is ignored.

## Configuration
- `RECT_OUTLINE_EN` defined:
  - `outline_in` port exists and is captured at `start`.
  - With captured outline=1, `writeEn` is asserted only where `qx`=0, `qx`=w−1, `qy`=0 or `qy`=h−1.
  - The scan still takes w·h cycles, so timing is identical to a fill.
  - With captured outline=0, the block behaves as a fill.
- `RECT_OUTLINE_EN` undefined: `outline_in` is absent and every DRAW cycle writes.

## Test plan
- Reset then idle: `resetn`=0 mid-run → all outputs 0 immediately (asynchronously); after release, state is IDLE and no `done` appears.
- Basic fill: start x=10, y=20, w=3, h=2, colour=5.
  - Writes (10,20), (10,21), (11,20), (11,21), (12,20), (12,21) at cycles 1–6 with `color_out`=5.
  - `done` at cycle 7.
- Zero size: w=0, h=4 → no `writeEn`; `done` at cycle 1; `busy` high only during cycle 1.
- Wrap: x=1022, w=4, h=1, COORD_W=10 → `x_out` sequence 1022, 1023, 0, 1; `done` at cycle 5.
- Ignored start: re-pulse `start` with new x during cycles 2 and 7 of a 3×2 job → original six writes unchanged; the second job does not run.
- Outline (`RECT_OUTLINE_EN`): x=0, y=0, w=3, h=3, outline=1 → 8 writes (all except (1,1)), `writeEn` low at cycle 5, `done` at cycle 10.

Source files
------------

// File: rtl/rect_fill_engine.sv
// -----------------------------------------------------------------------------
// rect_fill_engine
//
// Rectangle rasteriser for the VGA-adapter path. A one-cycle start in IDLE
// captures origin, width/height and colour, then one pixel per clock is emitted
// in column-major order (inner loop walks y, outer loop walks x). A zero width
// or height finishes immediately with no writes.
//
// Optional feature macro: RECT_OUTLINE_EN
//   When defined, an outline_in port exists. If outline is captured high, only
//   border pixels get a write strobe. The scan still visits every pixel, so the
//   job timing matches a fill.
//
// Ports:
//   clk, resetn         clock (rising edge), asynchronous active-low reset
//   start               one-cycle job request, honoured only in IDLE
//   x_in, y_in          top-left origin
//   w_in, h_in          rectangle size in pixels
//   color_in            fill colour
//   outline_in          outline-only request (RECT_OUTLINE_EN only)
//   busy                high in DRAW and DONE
//   done                one-cycle completion pulse
//   writeEn             pixel write strobe
//   x_out, y_out        pixel coordinate, valid while writeEn is high
//   color_out           colour captured at the last accepted start
//
// Handshake: start is a request sampled only while busy is low; requests seen
// while busy is high (including the done cycle) are dropped, not queued.
// -----------------------------------------------------------------------------
module rect_fill_engine #(
    parameter int COORD_W = 10,
    parameter int DIM_W   = 6,
    parameter int COLOR_W = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [DIM_W-1:0]   w_in,
    input  logic [DIM_W-1:0]   h_in,
    input  logic [COLOR_W-1:0] color_in,
`ifdef RECT_OUTLINE_EN
    input  logic               outline_in,
`endif
    output logic               busy,
    output logic               done,
    output logic               writeEn,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic [COLOR_W-1:0] color_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DIM_W-1:0] DIM_ZERO = '0;
    localparam logic [DIM_W-1:0] DIM_ONE  = 1;

    state_t             state;
    state_t             state_nx;

    logic [COORD_W-1:0] x0_r;
    logic [COORD_W-1:0] y0_r;
    logic [DIM_W-1:0]   w_r;
    logic [DIM_W-1:0]   h_r;
    logic [COLOR_W-1:0] color_r;
    logic [DIM_W-1:0]   qx;
    logic [DIM_W-1:0]   qy;
    logic [DIM_W-1:0]   w_m1;
    logic [DIM_W-1:0]   h_m1;
    logic               col_end;
    logic               last_px;
    logic               edge_px;

    assign w_m1    = w_r - DIM_ONE;
    assign h_m1    = h_r - DIM_ONE;
    assign col_end = (qy == h_m1);
    assign last_px = col_end && (qx == w_m1);

`ifdef RECT_OUTLINE_EN
    logic outline_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outline_r <= 1'b0;
        end else if (state == S_IDLE && start) begin
            outline_r <= outline_in;
        end
    end

    assign edge_px = !outline_r || (qx == DIM_ZERO) || (qx == w_m1) ||
                     (qy == DIM_ZERO) || col_end;
`else
    assign edge_px = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (w_in == DIM_ZERO || h_in == DIM_ZERO) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_DRAW;
                    end
                end
            end
            S_DRAW: begin
                if (last_px) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Job capture and scan counters. The counters fold back to zero on the
    // last pixel so they never reach the dimension value itself.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x0_r    <= '0;
            y0_r    <= '0;
            w_r     <= '0;
            h_r     <= '0;
            color_r <= '0;
            qx      <= '0;
            qy      <= '0;
        end else if (state == S_IDLE && start) begin
            x0_r    <= x_in;
            y0_r    <= y_in;
            w_r     <= w_in;
            h_r     <= h_in;
            color_r <= color_in;
            qx      <= '0;
            qy      <= '0;
        end else if (state == S_DRAW) begin
            if (col_end) begin
                qy <= '0;
                qx <= last_px ? DIM_ZERO : qx + DIM_ONE;
            end else begin
                qy <= qy + DIM_ONE;
            end
        end
    end

    // Outputs: decoded from the state register and datapath registers only,
    // so start never reaches writeEn combinationally.
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        writeEn   = (state == S_DRAW) && edge_px;
        x_out     = x0_r + COORD_W'(qx);
        y_out     = y0_r + COORD_W'(qy);
        color_out = color_r;
    end

endmodule
